load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sequencer between the CPU memory stage and DataMemory port 1. It accepts one RV64 load/store
//  request at a time and returns a sized, extended 64-bit load result.
//  It performs read-modify-write for SB/SH and issues two 32-bit accesses for LD/SD,
//  because DataMemory reads and writes exactly 4 bytes per access.
// PARAMETERS
//  XLEN      64  datapath width
//  MEM_BITS  10  implemented byte-address bits; higher address bits must be zero
// PORTS
//  clock         in   1     single clock, all state on posedge
//  rst           in   1     synchronous, active-high reset
//  req_valid     in   1     request present
//  req_ready     out  1     high only in IDLE; request accepted when req_valid&&req_ready
//  req_we        in   1     1=store, 0=load
//  req_funct3    in   3     RV funct3 (LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110; SB..SD 000..011)
//  req_addr      in   XLEN  byte address
//  req_wdata     in   XLEN  store data
//  resp_valid    out  1     response held until resp_ready
//  resp_ready    in   1     consumer accepts response
//  resp_rdata    out  XLEN  load result; 0 for stores and errors
//  resp_err      out  1     illegal funct3, or req_addr[XLEN-1:MEM_BITS]!=0
//  mem_read_en   out  1     to MemReadEn1; data on mem_rdata the next cycle
//  mem_write_en  out  1     to MemWriteEn1; writes 4 bytes at mem_addr..+3
//  mem_addr      out  XLEN  to AddressBus1
//  mem_wdata     out  XLEN  to DataMemoryInput1; only [31:0] used, [63:32]=0
//  mem_rdata     in   XLEN  from DataMemoryOutput1; only [31:0] used
// BEHAVIOUR
//  Request capture
//  - On accept, latch we, funct3, addr and wdata. Later changes on req_* are ignored.
//  FSM states: IDLE, RD_A, RD_B, RD_C, WR_A, WR_B, RESP. Memory controls are decoded from the state.
//  - IDLE: on accept go to ERR->RESP if the request is illegal; no memory access is made.
//    Otherwise loads and SB/SH go to RD_A; SW/SD go to WR_A.
//  - RD_A: mem_read_en=1, mem_addr=addr.
//  - RD_B: lo<=mem_rdata[31:0].
//    LD: mem_read_en=1, mem_addr=addr+4, go to RD_C.
//    SB/SH: go to WR_A. Other loads: go to RESP.
//  - RD_C: hi<=mem_rdata[31:0], go to RESP.
//  - WR_A: mem_write_en=1, mem_addr=addr.
//    mem_wdata = SB {lo[31:8],wdata[7:0]}; SH {lo[31:16],wdata[15:0]}; SW/SD wdata[31:0].
//    SD goes to WR_B, all others go to RESP.
//  - WR_B: mem_write_en=1, mem_addr=addr+4, mem_wdata=wdata[63:32], go to RESP.
//  - RESP: resp_valid=1, outputs stable. On resp_ready go to IDLE; no same-cycle re-accept.
//  Load extension (from lo): LB/LH/LW sign-extend bit 7/15/31; LBU/LHU/LWU zero-extend; LD={hi,lo}.
//  Latency, accept edge to resp_valid high (cycles):
//    LB/LH/LW/LBU/LHU/LWU 3; LD 4; SW 2; SD 3; SB/SH 4; error 1.
//  Address arithmetic: addr+4 is computed in XLEN bits. The memory uses only [MEM_BITS-1:0],
//  so accesses that run past the top wrap to byte 0.
//  Idle outputs: mem_read_en=mem_write_en=0; mem_addr/mem_wdata=0 outside RD/WR states.
//  Reset
//  - Next state is IDLE; resp_valid=0, resp_rdata=0, resp_err=0, lo=hi=0.
//  - mem_write_en and mem_read_en are gated combinationally by !rst, so no access commits
//    in a reset cycle, including a reset taken mid-operation (e.g. between WR_A and WR_B).
//  resp_ready asserted while resp_valid=0 is ignored.
//  Illegal encodings: funct3 111 for loads, funct3 1xx for stores.
// TESTING
//  - Preload Mem[16..19]=80,FF,00,00. LB@16 -> FFFF_FFFF_FFFF_FF80 at cycle 3.
//    LBU@16 -> 0x80. LH@16 -> FFFF_FFFF_FFFF_FF80. LHU@16 -> 0xFF80.
//  - SD@8 wdata=1122334455667788: two writes, then LD@8 -> 1122334455667788 (LW@12 -> 0x11223344).
//  - SB@20 wdata=..AB over word CAFEBABE: Mem[20..23]=AB,BA,FE,CA.
//    Exactly one read and one write are issued; resp at cycle 4.
//  - Illegal cases: store funct3=100 -> resp_err=1 at cycle 1, no mem_*_en pulse.
//    Load addr=0x400 (MEM_BITS=10) -> resp_err=1, resp_rdata=0.
//  - Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable and req_ready=0 throughout.
//  - Reset in WR_B of SD@0: Mem[4..7] unchanged; next cycle req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer between the memory stage and a 4-byte-wide data memory port.
// Latency (accept edge to resp_valid): loads 3, LD 4, SW 2, SD 3, SB/SH 4, errors 1.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
//
// Ports:
//   clock, rst                  clock and synchronous active-high reset
//   req_valid/req_ready         request handshake; req_we, req_funct3, req_addr, req_wdata
//   resp_valid/resp_ready       response handshake; resp_rdata (load result), resp_err
//   mem_read_en, mem_write_en   memory strobes (read data returns on mem_rdata next cycle)
//   mem_addr, mem_wdata         memory address and 32-bit write word (upper half zero)
//   mem_rdata                   memory read word (lower 32 bits used)
module load_store_unit #(
    parameter int XLEN     = 64,
    parameter int MEM_BITS = 10
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read_en,
    output logic            mem_write_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        RD_C,
        WR_A,
        WR_B,
        RESP
    } stateType;

    stateType        state, nextState;
    logic            weReg;
    logic [2:0]      funct3Reg;
    logic [XLEN-1:0] addrReg;
    logic [XLEN-1:0] wdataReg;
    logic            errReg;
    logic [31:0]     lo, hi;

    logic            accept;
    logic            reqIllegal;
    logic            isLoadDouble;
    logic            isDouble;
    logic            memReadRaw, memWriteRaw;
    logic [XLEN-1:0] addrPlus4;
    logic [XLEN-1:0] loadResult;

    // Memory returns only the low word; the upper half is intentionally ignored.
    logic unusedRdataHi;
    assign unusedRdataHi = ^mem_rdata[XLEN-1:32];

    assign accept       = req_valid && req_ready;
    assign reqIllegal   = (req_we && req_funct3[2])
                       || (!req_we && req_funct3 == 3'b111)
                       || (req_addr[XLEN-1:MEM_BITS] != '0);
    assign isDouble     = (funct3Reg[1:0] == 2'b11);
    assign isLoadDouble = !weReg && isDouble;
    // Full-width add; the memory only decodes the low MEM_BITS, so overflow wraps to byte 0.
    assign addrPlus4    = addrReg + XLEN'(4);

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            weReg     <= 1'b0;
            funct3Reg <= 3'b000;
            addrReg   <= '0;
            wdataReg  <= '0;
            errReg    <= 1'b0;
            lo        <= '0;
            hi        <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                weReg     <= req_we;
                funct3Reg <= req_funct3;
                addrReg   <= req_addr;
                wdataReg  <= req_wdata;
                errReg    <= reqIllegal;
            end
            if (state == RD_B) lo <= mem_rdata[31:0];
            if (state == RD_C) hi <= mem_rdata[31:0];
        end
    end

    always_comb begin
        nextState   = state;
        memReadRaw  = 1'b0;
        memWriteRaw = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (reqIllegal)                   nextState = RESP;
                    else if (req_we && req_funct3[1]) nextState = WR_A;   // SW/SD skip the read
                    else                              nextState = RD_A;
                end
            end
            RD_A: begin
                memReadRaw = 1'b1;
                mem_addr   = addrReg;
                nextState  = RD_B;
            end
            RD_B: begin
                if (isLoadDouble) begin
                    memReadRaw = 1'b1;
                    mem_addr   = addrPlus4;
                    nextState  = RD_C;
                end else if (weReg) begin
                    nextState = WR_A;                 // SB/SH merge into the word just read
                end else begin
                    nextState = RESP;
                end
            end
            RD_C: nextState = RESP;
            WR_A: begin
                memWriteRaw = 1'b1;
                mem_addr    = addrReg;
                case (funct3Reg[1:0])
                    2'b00:   mem_wdata = XLEN'({lo[31:8], wdataReg[7:0]});
                    2'b01:   mem_wdata = XLEN'({lo[31:16], wdataReg[15:0]});
                    default: mem_wdata = XLEN'(wdataReg[31:0]);
                endcase
                nextState = isDouble ? WR_B : RESP;
            end
            WR_B: begin
                memWriteRaw = 1'b1;
                mem_addr    = addrPlus4;
                mem_wdata   = XLEN'(wdataReg[XLEN-1:32]);
                nextState   = RESP;
            end
            RESP: if (resp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Strobes are masked by reset so an access interrupted mid-sequence never commits.
    assign mem_read_en  = memReadRaw && !rst;
    assign mem_write_en = memWriteRaw && !rst;

    always_comb begin
        loadResult = '0;
        case (funct3Reg)
            3'b000:  loadResult = {{(XLEN-8){lo[7]}}, lo[7:0]};
            3'b001:  loadResult = {{(XLEN-16){lo[15]}}, lo[15:0]};
            3'b010:  loadResult = {{(XLEN-32){lo[31]}}, lo};
            3'b011:  loadResult = {hi, lo};
            3'b100:  loadResult = XLEN'(lo[7:0]);
            3'b101:  loadResult = XLEN'(lo[15:0]);
            3'b110:  loadResult = XLEN'(lo);
            default: loadResult = '0;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && errReg;
    assign resp_rdata = ((state == RESP) && !errReg && !weReg) ? loadResult : '0;

endmodule
